// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-enable type for the AHB SRAM slave.
// The ERR1/ERR2 states are only reachable when AHB_SRAM_ERR_RESP_EN is defined.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_STALL = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } state_e;

    typedef logic [3:0] be_t;

endpackage

// File: rtl/ahb_sram_be_gen.sv
// Little-endian byte-enable decode from AHB transfer size and the low two address bits.
// Sizes above word fall back to a full-word enable.
module ahb_sram_be_gen
    import ahb_sram_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output be_t        be_o
);

    always_comb begin
        be_o = 4'b1111;
        case (hsize_i)
            HSIZE_BYTE: be_o = 4'b0001 << addr_i;
            HSIZE_HALF: be_o = addr_i[1] ? 4'b1100 : 4'b0011;
            default:    be_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slv.sv
// AHB-Lite slave driving a single-port synchronous SRAM (1-cycle read latency), zero wait states
// except one stall on a read right behind a write. Define AHB_SRAM_ERR_RESP_EN for ERROR responses.
module ahb_sram_slv
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic                  hready,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [31:0]           haddr,
    input  logic [31:0]           hwdata,
    output logic                  hready_resp,
    output logic [1:0]            hresp,
    output logic [31:0]           hrdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic [2:0]            state_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    be_t                   wbe_q, wbe_d;
    be_t                   be_new;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic                  req, accept, bad_beat;
    logic                  unused_sig;

    // req ignores hready so the WR-state conflict check never loops through hready_resp
    assign req        = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign accept     = req && hready;
    assign haddr_word = haddr[ADDR_WIDTH+1:2];

`ifdef AHB_SRAM_ERR_RESP_EN
    assign bad_beat = (haddr[31:ADDR_WIDTH+2] != '0) || (hsize > HSIZE_WORD);
`else
    assign bad_beat = 1'b0;
`endif

    assign unused_sig = ^{hburst, haddr[31:ADDR_WIDTH+2]};
    assign state_o    = state_q;

    ahb_sram_be_gen u_be_gen (
        .hsize_i (hsize),
        .addr_i  (haddr[1:0]),
        .be_o    (be_new)
    );

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        wbe_d       = wbe_q;
        raddr_d     = raddr_q;
        hready_resp = 1'b1;
        hresp       = HRESP_OKAY;
        hrdata      = (state_q == ST_RD) ? sram_rdata : '0;
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_be     = '0;
        sram_addr   = '0;
        sram_wdata  = '0;

        case (state_q)
            ST_WR: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = wbe_q;
                sram_addr  = waddr_q;
                sram_wdata = hwdata;
                if (req && bad_beat) begin
                    state_d = ST_ERR1;
                end else if (req && !hwrite) begin
                    // SRAM port busy with the write: hold the read one cycle
                    hready_resp = 1'b0;
                    raddr_d     = haddr_word;
                    state_d     = ST_STALL;
                end else if (req) begin
                    waddr_d = haddr_word;
                    wbe_d   = be_new;
                    state_d = ST_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                sram_cs   = 1'b1;
                sram_be   = 4'b1111;
                sram_addr = raddr_q;
                state_d   = ST_RD;
            end
            ST_ERR1: begin
                hresp       = HRESP_ERROR;
                hready_resp = 1'b0;
                state_d     = ST_ERR2;
            end
            default: begin
                if (state_q == ST_ERR2) hresp = HRESP_ERROR;
                if (accept && bad_beat) begin
                    state_d = ST_ERR1;
                end else if (accept && hwrite) begin
                    waddr_d = haddr_word;
                    wbe_d   = be_new;
                    state_d = ST_WR;
                end else if (accept) begin
                    sram_cs   = 1'b1;
                    sram_be   = 4'b1111;
                    sram_addr = haddr_word;
                    state_d   = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (hreset) begin
            sram_cs = 1'b0;
            sram_we = 1'b0;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            raddr_q <= '0;
            wbe_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wbe_q   <= wbe_d;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slv.sv
// Directed bench for ahb_sram_slv: single-slave bus (hready tied to hready_resp) and a
// behavioural 1-cycle-latency SRAM; expected values are hand-computed constants.
module tb_ahb_sram_slv;
    import ahb_sram_pkg::*;

    localparam int AW = 14;

    logic          hclk = 1'b0;
    logic          hreset;
    logic          hsel, hwrite;
    logic [1:0]    htrans;
    logic [2:0]    hsize, hburst;
    logic [31:0]   haddr, hwdata;
    logic          hready_resp;
    logic [1:0]    hresp;
    logic [31:0]   hrdata;
    logic          sram_cs, sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = '0;
    logic [2:0]    state_o;

    logic [31:0]   mem [0:(1<<AW)-1] = '{default: '0};
    logic [31:0]   exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // ---------------- clock / DUT / SRAM model ----------------
    always #5 hclk = ~hclk;

    ahb_sram_slv #(.ADDR_WIDTH(AW)) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .hsel        (hsel),
        .hready      (hready_resp),
        .hwrite      (hwrite),
        .htrans      (htrans),
        .hsize       (hsize),
        .hburst      (hburst),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .hready_resp (hready_resp),
        .hresp       (hresp),
        .hrdata      (hrdata),
        .sram_cs     (sram_cs),
        .sram_we     (sram_we),
        .sram_be     (sram_be),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .state_o     (state_o)
    );

    always @(posedge hclk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge hclk);
        #1;
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
        hwdata = wdata;
        #1;
    endtask

    task automatic idle(input logic [31:0] wdata);
        drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wdata);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        hreset = 1'b1;
        hsel   = 1'b0;
        hwrite = 1'b0;
        htrans = HTRANS_IDLE;
        hsize  = HSIZE_WORD;
        hburst = 3'd0;
        haddr  = '0;
        hwdata = '0;
        #12;
        check("rst_ready", {31'd0, hready_resp}, 32'd1);
        check("rst_hresp", {30'd0, hresp}, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_cs", {31'd0, sram_cs}, 32'd0);
        check("rst_state", {29'd0, state_o}, 32'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;

        // reset in the data phase of a write drops the write
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40, 32'h0);
        check("wr_aphase_cs", {31'd0, sram_cs}, 32'd0);
        @(posedge hclk);
        #1;
        check("wr_dphase_state", {29'd0, state_o}, 32'd2);
        hreset = 1'b1;
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b0;
        haddr  = 32'h44;
        hwdata = 32'h5555_5555;
        #1;
        check("midrst_state", {29'd0, state_o}, 32'd0);
        check("midrst_cs", {31'd0, sram_cs}, 32'd0);
        check("midrst_ready", {31'd0, hready_resp}, 32'd1);
        check("midrst_hresp", {30'd0, hresp}, 32'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;

        // write then read the same word: one stall, then new data
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hDEAD_BEEF);
        check("raw_wr_cs_we", {30'd0, sram_cs, sram_we}, 32'd3);
        check("raw_wr_data", sram_wdata, 32'hDEAD_BEEF);
        check("raw_wr_addr", {18'd0, sram_addr}, 32'd4);
        check("raw_wr_be", {28'd0, sram_be}, 32'hF);
        check("raw_stall_ready", {31'd0, hready_resp}, 32'd0);
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        check("raw_stall_state", {29'd0, state_o}, 32'd3);
        check("raw_stall_rd", {30'd0, sram_cs, sram_we}, 32'd2);
        check("raw_stall_ready2", {31'd0, hready_resp}, 32'd1);
        idle(32'h0);
        check("raw_rdata", hrdata, 32'hDEAD_BEEF);
        check("raw_hresp", {30'd0, hresp}, 32'd0);

        // byte write into the top lane, then word read shows the merge
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13, 32'h0);
        idle(32'hAA00_0000);
        check("byte_be", {28'd0, sram_be}, 32'h8);
        check("byte_wdata", sram_wdata, 32'hAA00_0000);
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        check("byte_rd_addr", {18'd0, sram_addr}, 32'd4);
        idle(32'h0);
        check("byte_merge", hrdata, 32'hAAAD_BEEF);
        idle(32'h0);
        check("idle_hrdata", hrdata, 32'd0);

        // halfword + byte writes back to back, then a read behind a write
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h16, 32'h0);
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h15, 32'h1234_0000);
        check("half_be", {28'd0, sram_be}, 32'hC);
        check("half_addr", {18'd0, sram_addr}, 32'd5);
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h14, 32'h0000_CD00);
        check("byte1_be", {28'd0, sram_be}, 32'h2);
        check("byte1_stall", {31'd0, hready_resp}, 32'd0);
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h14, 32'h0);
        idle(32'h0);
        check("half_merge", hrdata, 32'h1234_CD00);

        // INCR4 preload 1..4 at 0x20..0x2C, then INCR4 read back
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h20 + 32'(4 * i), 32'(i));
            check("wstream_ready", {31'd0, hready_resp}, 32'd1);
            check("wstream_addr", {18'd0, sram_addr}, 32'(7 + i));
        end
        idle(32'd4);
        check("wstream_last", sram_wdata, 32'd4);
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
        check("rstream_first_cs", {30'd0, sram_cs, sram_we}, 32'd2);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) drive(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h20 + 32'(4 * i), 32'h0);
            else       idle(32'h0);
            check("rstream_ready", {31'd0, hready_resp}, 32'd1);
            check("rstream_data", hrdata, exp_q.pop_front());
        end

        // BUSY between SEQ writes
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h0);
        drive(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h34, 32'h1111_1111);
        check("busy_wr_cs", {31'd0, sram_cs}, 32'd1);
        drive(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h34, 32'h0);
        check("busy_no_cs", {31'd0, sram_cs}, 32'd0);
        check("busy_okay", {29'd0, hresp, hready_resp}, 32'd1);
        drive(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h34, 32'h0);
        idle(32'h2222_2222);
        check("busy_wr2_addr", {18'd0, sram_addr}, 32'hD);
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'h0);
        drive(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h34, 32'h0);
        check("busy_rd1", hrdata, 32'h1111_1111);
        idle(32'h0);
        check("busy_rd2", hrdata, 32'h2222_2222);

        // the write dropped by reset never reached the SRAM
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40, 32'h0);
        idle(32'h0);
        check("dropped_wr", hrdata, 32'h0);

`ifdef AHB_SRAM_ERR_RESP_EN
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0001_0000, 32'h0);
        check("err_no_cs", {31'd0, sram_cs}, 32'd0);
        idle(32'h0);
        check("err1_resp", {29'd0, hresp, hready_resp}, 32'h2);
        check("err1_no_cs", {31'd0, sram_cs}, 32'd0);
        idle(32'h0);
        check("err2_resp", {29'd0, hresp, hready_resp}, 32'h3);
        idle(32'h0);
        check("err_done", {29'd0, hresp, hready_resp}, 32'h1);
`else
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0001_0010, 32'h0);
        check("wrap_addr", {18'd0, sram_addr}, 32'd4);
        idle(32'h0);
        check("wrap_data", hrdata, 32'hAAAD_BEEF);
        check("wrap_okay", {30'd0, hresp}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
